// File: rtl/photon_hls_dl_pkg.sv
// Shared definitions for the photon HLS deadlock report controller:
// FSM state encodings and width helpers for the process index and trace counter.
package photon_hls_dl_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ORIGIN = 3'd1;
    localparam logic [2:0] ST_TRACE  = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Process index width; never narrower than one bit
    function automatic int dl_id_w(input int proc_num);
        return (proc_num <= 2) ? 1 : $clog2(proc_num);
    endfunction

    // Trace counter width, wide enough to hold TIMEOUT itself
    function automatic int dl_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/photon_hls_dl_origin_arb.sv
// Origin picker for the deadlock report controller. Combinationally selects one
// requesting detect unit. Default: lowest set index wins. With DL_REPORT_RR_EN
// defined, a pointer (last winner + 1) sets the search start and wraps.
module photon_hls_dl_origin_arb
    import photon_hls_dl_pkg::*;
#(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = dl_id_w(PROC_NUM)
) (
    input  logic                clock_i,
    input  logic                reset_i,    // active-low, synchronous
    input  logic [PROC_NUM-1:0] req_i,
    input  logic                take_i,     // grant consumed (IDLE->ORIGIN)
    output logic                gnt_vld_o,
    output logic [ID_W-1:0]     gnt_id_o
);

    assign gnt_vld_o = |req_i;

`ifdef DL_REPORT_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   slot;
    logic            found;

    // Search from ptr upward, wrapping at PROC_NUM
    always_comb begin
        gnt_id_o = '0;
        found    = 1'b0;
        slot     = '0;
        for (int k = 0; k < PROC_NUM; k++) begin
            slot = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (slot >= (ID_W+1)'(PROC_NUM)) slot = slot - (ID_W+1)'(PROC_NUM);
            if (!found && req_i[slot[ID_W-1:0]]) begin
                found    = 1'b1;
                gnt_id_o = slot[ID_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner whenever a grant is taken
    always_comb begin
        ptr_d = ptr_q;
        if (take_i) begin
            ptr_d = (gnt_id_o == ID_W'(PROC_NUM-1)) ? '0 : gnt_id_o + ID_W'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clock_i) begin
        if (!reset_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clock_i, reset_i, take_i};

    // Fixed priority: scan downward so the lowest set index is written last
    always_comb begin
        gnt_id_o = '0;
        for (int i = PROC_NUM-1; i >= 0; i--) begin
            if (req_i[i]) gnt_id_o = ID_W'(i);
        end
    end
`endif

endmodule

// File: rtl/photon_hls_deadlock_report_ctrl.sv
// Central deadlock report sequencer for the photon HLS dataflow region.
// Picks one origin among the asserting detect units, launches a single report
// token around the dependence cycle, traces which processes see it, and
// publishes one report (origin, mask, length, timeout) over valid/ready.
// Optional build macro: DL_REPORT_RR_EN selects round-robin origin arbitration.
module photon_hls_deadlock_report_ctrl
    import photon_hls_dl_pkg::*;
#(
    parameter  int PROC_NUM = 4,
    parameter  int TIMEOUT  = 1023,
    localparam int ID_W     = dl_id_w(PROC_NUM),
    localparam int CNT_W    = dl_cnt_w(TIMEOUT)
) (
    input  logic                clock_i,
    input  logic                reset_i,          // active-low, synchronous
    input  logic [PROC_NUM-1:0] dl_detect_vec_i,
    input  logic [PROC_NUM-1:0] token_obs_vec_i,
    input  logic                rearm_i,
    output logic                dl_detect_in_o,
    output logic [PROC_NUM-1:0] origin_vec_o,
    output logic [PROC_NUM-1:0] token_clear_vec_o,
    output logic                report_vld_o,
    input  logic                report_rdy_i,
    output logic [ID_W-1:0]     report_origin_o,
    output logic [PROC_NUM-1:0] report_mask_o,
    output logic [CNT_W-1:0]    report_len_o,
    output logic                report_timeout_o,
    output logic                busy_o
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic [2:0]          state_q,     state_d;
    logic [ID_W-1:0]     origin_id_q, origin_id_d;
    logic [PROC_NUM-1:0] mask_q,      mask_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [PROC_NUM-1:0] rpt_mask_q,  rpt_mask_d;
    logic [CNT_W-1:0]    rpt_len_q,   rpt_len_d;
    logic                rpt_tmo_q,   rpt_tmo_d;

    logic                gnt_vld;
    logic [ID_W-1:0]     gnt_id;
    logic                take;
    logic [PROC_NUM-1:0] origin_oh;
    logic                close;
    logic                tmo_hit;

    assign take = (state_q == ST_IDLE) && gnt_vld;

    photon_hls_dl_origin_arb #(
        .PROC_NUM (PROC_NUM),
        .ID_W     (ID_W)
    ) u_arb (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .req_i     (dl_detect_vec_i),
        .take_i    (take),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // One-hot of the latched origin plus the trace termination conditions
    always_comb begin
        origin_oh = '0;
        origin_oh[origin_id_q] = 1'b1;
        close   = (state_q == ST_TRACE) && dl_detect_vec_i[origin_id_q];
        tmo_hit = (cnt_q == TMO);
    end

    // Next-state and datapath updates; a close in the same cycle as timeout wins
    always_comb begin
        state_d     = state_q;
        origin_id_d = origin_id_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        rpt_mask_d  = rpt_mask_q;
        rpt_len_d   = rpt_len_q;
        rpt_tmo_d   = rpt_tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    origin_id_d = gnt_id;
                    state_d     = ST_ORIGIN;
                end
            end
            ST_ORIGIN: begin
                mask_d  = origin_oh;
                cnt_d   = '0;
                state_d = ST_TRACE;
            end
            ST_TRACE: begin
                mask_d = mask_q | token_obs_vec_i;
                cnt_d  = tmo_hit ? cnt_q : cnt_q + CNT_W'(1);
                if (close) begin
                    state_d    = ST_REPORT;
                    rpt_mask_d = mask_q | token_obs_vec_i;
                    rpt_len_d  = cnt_q;
                    rpt_tmo_d  = 1'b0;
                end else if (tmo_hit) begin
                    state_d    = ST_REPORT;
                    rpt_mask_d = mask_q | token_obs_vec_i;
                    rpt_len_d  = TMO;
                    rpt_tmo_d  = 1'b1;
                end
            end
            ST_REPORT: begin
                if (report_rdy_i) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rearm_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            origin_id_q <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            rpt_mask_q  <= '0;
            rpt_len_q   <= '0;
            rpt_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            origin_id_q <= origin_id_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            rpt_mask_q  <= rpt_mask_d;
            rpt_len_q   <= rpt_len_d;
            rpt_tmo_q   <= rpt_tmo_d;
        end
    end

    // Output decode: token_clear is combinational so the origin is cleared in the close cycle
    always_comb begin
        dl_detect_in_o    = (state_q != ST_IDLE);
        busy_o            = (state_q != ST_IDLE);
        origin_vec_o      = (state_q == ST_ORIGIN) ? origin_oh : '0;
        token_clear_vec_o = close ? origin_oh : '0;
        report_vld_o      = (state_q == ST_REPORT);
        report_origin_o   = origin_id_q;
        report_mask_o     = rpt_mask_q;
        report_len_o      = rpt_len_q;
        report_timeout_o  = rpt_tmo_q;
    end

endmodule

// File: tb/tb_photon_hls_deadlock_report_ctrl.sv
// Randomized self-checking bench for photon_hls_deadlock_report_ctrl.
// Each deadlock episode is modelled at transaction level: expected origin from
// the arbitration rule, expected mask/len/timeout from the trace rules.
module tb_photon_hls_deadlock_report_ctrl;

    localparam int N   = 4;
    localparam int TMO = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] dl_vec, obs_vec;
    logic         rearm, rdy;
    logic         dl_in, vld, tmo_o, busy;
    logic [N-1:0] origin_vec, tok_clr, mask_o;
    logic [1:0]   origin_o;
    logic [2:0]   len_o;

    int n_chk  = 0;
    int n_pass = 0;
    int rr_ptr = 0;

    always #5 clk = ~clk;

    photon_hls_deadlock_report_ctrl #(.PROC_NUM(N), .TIMEOUT(TMO)) dut (
        .clock_i           (clk),
        .reset_i           (rst_n),
        .dl_detect_vec_i   (dl_vec),
        .token_obs_vec_i   (obs_vec),
        .rearm_i           (rearm),
        .dl_detect_in_o    (dl_in),
        .origin_vec_o      (origin_vec),
        .token_clear_vec_o (tok_clr),
        .report_vld_o      (vld),
        .report_rdy_i      (rdy),
        .report_origin_o   (origin_o),
        .report_mask_o     (mask_o),
        .report_len_o      (len_o),
        .report_timeout_o  (tmo_o),
        .busy_o            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference arbitration: which requester becomes origin
    function automatic int pick(input logic [N-1:0] req);
`ifdef DL_REPORT_RR_EN
        for (int k = 0; k < N; k++) if (req[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
`else
        for (int i = 0; i < N; i++) if (req[i]) return i;
`endif
        return 0;
    endfunction

    // One full episode: detect, origin pulse, trace, report handshake, done, rearm
    task automatic episode(input logic [N-1:0] req, input int close_k,
                           input int rdy_dly, input bit rnd_obs);
        int           org, exp_len;
        bit           exp_tmo, fin;
        logic [N-1:0] oh, exp_mask, obs, det;
        org = pick(req);
        rr_ptr = (org + 1) % N;
        oh = N'(1 << org);
        exp_len = 0; exp_tmo = 0; fin = 0;

        @(negedge clk); dl_vec = req; obs_vec = '0; rearm = 0; rdy = 0; #1;
        chk("idle_busy", busy, 0);
        chk("idle_dlin", dl_in, 0);
        chk("idle_org", origin_vec, 0);

        @(negedge clk); dl_vec = '0; obs_vec = N'($urandom); #1;
        chk("origin_vec", origin_vec, oh);
        chk("origin_dlin", dl_in, 1);

        exp_mask = oh;
        for (int k = 0; k <= TMO && !fin; k++) begin
            @(negedge clk);
            obs = rnd_obs ? N'($urandom) : (k == 1 ? 4'b0100 : (k == 2 ? 4'b1000 : 4'b0000));
            det = N'($urandom) & ~oh;
            if (k == close_k) det = det | oh;
            dl_vec = det; obs_vec = obs; rearm = ($urandom_range(0, 3) == 0); #1;
            chk("trace_clr", tok_clr, (k == close_k) ? oh : '0);
            chk("trace_org", origin_vec, 0);
            chk("trace_vld", vld, 0);
            chk("trace_dlin", dl_in, 1);
            exp_mask = exp_mask | obs;
            if (k == close_k) begin
                exp_len = k; exp_tmo = 0; fin = 1;
            end else if (k == TMO) begin
                exp_len = TMO; exp_tmo = 1; fin = 1;
            end
        end

        for (int d = 0; d <= rdy_dly; d++) begin
            @(negedge clk);
            dl_vec = N'($urandom); obs_vec = N'($urandom); rearm = 0; rdy = (d == rdy_dly); #1;
            chk("rpt_vld", vld, 1);
            chk("rpt_origin", origin_o, org);
            chk("rpt_mask", mask_o, exp_mask);
            chk("rpt_len", len_o, exp_len);
            chk("rpt_tmo", tmo_o, exp_tmo);
            chk("rpt_clr", tok_clr, 0);
        end

        repeat (2) begin
            @(negedge clk); rdy = 1'($urandom); dl_vec = N'($urandom); #1;
            chk("done_vld", vld, 0);
            chk("done_dlin", dl_in, 1);
            chk("done_busy", busy, 1);
        end
        @(negedge clk); dl_vec = '0; rdy = 0; rearm = 1; #1;
        chk("rearm_dlin", dl_in, 1);
    endtask

    // Reset asserted for one edge while tracing from origin 2 with cnt=5
    task automatic reset_mid_trace();
        @(negedge clk); dl_vec = 4'b0100; obs_vec = '0; rearm = 0; rdy = 0;
        @(negedge clk); dl_vec = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); dl_vec = 4'b0011; obs_vec = 4'b1001;
        end
        @(negedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 0;
        @(negedge clk); rst_n = 1; dl_vec = '0; obs_vec = '0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_dlin", dl_in, 0);
        chk("rst_vld", vld, 0);
        chk("rst_mask", mask_o, 0);
        chk("rst_len", len_o, 0);
        rr_ptr = 0;
    endtask

    initial begin
        rst_n = 0; dl_vec = '0; obs_vec = '0; rearm = 0; rdy = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_dlin", dl_in, 0);
        chk("init_vld", vld, 0);
        chk("init_org", origin_vec, 0);
        chk("init_clr", tok_clr, 0);
        chk("init_len", len_o, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); #1;
        chk("idle_hold", busy, 0);

        reset_mid_trace();

        episode(4'b0110, 3, 0, 0);          // origin 1, mask 1110, len 3
        episode(4'b0001, TMO + 3, 10, 1);   // never closes: timeout, rdy held low 10 cycles
        episode(4'b1000, TMO, 2, 1);        // close coincides with timeout: close wins
        episode(4'b0010, 0, 0, 1);          // immediate close
        repeat (3) episode(4'b1111, $urandom_range(0, TMO), 0, 1);
        repeat (20) episode(N'($urandom_range(1, 15)), $urandom_range(0, TMO + 2),
                            $urandom_range(0, 4), 1);

        @(negedge clk); rearm = 0; #1;
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
